// File: rtl/sys_bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge.
package sys_bridge_pkg;

  // Default device windows; each window spans 64 bytes (16 words).
  localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7F40;
  localparam logic [31:0] IRQ_BASE_DEF  = 32'h0000_7F80;
  localparam int          WIN_BYTES     = 64;

  // Number of interrupt lines collected: {DEV_IRQ1, DEV_IRQ0}.
  localparam int IRQ_W = 6;

  // Word offsets of the bridge-internal registers inside the IRQ window.
  localparam logic [3:0] REG_PEND = 4'd0;
  localparam logic [3:0] REG_MASK = 4'd1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    T_DEV0,
    T_DEV1,
    T_IRQ,
    T_NONE
  } target_t;

  // Map the upper word-address bits (byte address [31:6]) onto a target.
  function automatic target_t decode_target(
    input logic [25:0] addr_hi,
    input logic [25:0] dev0_hi,
    input logic [25:0] dev1_hi,
    input logic [25:0] irq_hi
  );
    if (addr_hi == dev0_hi)      return T_DEV0;
    else if (addr_hi == dev1_hi) return T_DEV1;
    else if (addr_hi == irq_hi)  return T_IRQ;
    else                         return T_NONE;
  endfunction

endpackage

// File: rtl/sys_bridge_irq_pend.sv
// Interrupt collector: rising-edge detect, write-1-to-clear pending bits
// with set priority, a mask register and the masked HWInt output.
module irq_pend
  import sys_bridge_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [IRQ_W-1:0] irq_in,
  input  logic [IRQ_W-1:0] clr,
  input  logic             mask_we,
  input  logic [IRQ_W-1:0] mask_wd,
  output logic [IRQ_W-1:0] pend,
  output logic [IRQ_W-1:0] mask,
  output logic [IRQ_W-1:0] hwint
);

  logic [IRQ_W-1:0] irq_q;
  logic [IRQ_W-1:0] rise;

  assign rise = irq_in & ~irq_q;

  // Sample the lines, update pending (a new edge beats a same-cycle clear) and the mask.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      irq_q <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      irq_q <= irq_in;
      pend  <= (pend & ~clr) | rise;
      if (mask_we) mask <= mask_wd;
    end
  end

  assign hwint = pend & mask;

endmodule

// File: rtl/sys_bridge.sv
// CPU data-port to peripheral-bus bridge: address decode, fixed
// IDLE/ACCESS/RESP handshake, read-data return and interrupt collection.
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF,
  parameter logic [31:0] IRQ_BASE  = IRQ_BASE_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [29:0] PrAddr,
  input  logic        PrReq,
  input  logic        PrWE,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic        PrReady,
  output logic        PrErr,
  output logic [5:0]  HWInt,
  output logic [3:0]  DEV_ADD,
  output logic [31:0] DEV_WD,
  output logic        DEV_WE,
  output logic [1:0]  DEV_STB,
  input  logic [31:0] DEV_RD0,
  input  logic [31:0] DEV_RD1,
  input  logic [2:0]  DEV_IRQ0,
  input  logic [2:0]  DEV_IRQ1
);

  state_t           state_q, state_d;
  target_t          tgt_q;
  logic [3:0]       idx_q;
  logic             we_q;
  logic [31:0]      wd_q;
  logic [31:0]      rd_q;
  logic [31:0]      rd_mux;

  logic [IRQ_W-1:0] irq_pend_v;
  logic [IRQ_W-1:0] irq_mask_v;
  logic [IRQ_W-1:0] irq_clr;
  logic             irq_mask_we;
  logic             irq_wr;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: every accepted request takes exactly three cycles.
  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (PrReq) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: strobe only device targets in ACCESS, completion pulse in RESP.
  always_comb begin
    DEV_STB = 2'b00;
    DEV_WE  = 1'b0;
    PrReady = 1'b0;
    PrErr   = 1'b0;
    unique case (state_q)
      ACCESS: begin
        if (tgt_q == T_DEV0) begin
          DEV_STB = 2'b01;
          DEV_WE  = we_q;
        end else if (tgt_q == T_DEV1) begin
          DEV_STB = 2'b10;
          DEV_WE  = we_q;
        end
      end
      RESP: begin
        PrReady = 1'b1;
        PrErr   = (tgt_q == T_NONE);
      end
      default: ;
    endcase
  end

  assign DEV_ADD = idx_q;
  assign DEV_WD  = wd_q;
  assign PrRD    = rd_q;

  // Read-data source for the access in flight; unmapped and spare slots read 0.
  always_comb begin
    rd_mux = '0;
    unique case (tgt_q)
      T_DEV0: rd_mux = DEV_RD0;
      T_DEV1: rd_mux = DEV_RD1;
      T_IRQ: begin
        if (idx_q == REG_PEND)      rd_mux = {{(32-IRQ_W){1'b0}}, irq_pend_v};
        else if (idx_q == REG_MASK) rd_mux = {{(32-IRQ_W){1'b0}}, irq_mask_v};
      end
      default: rd_mux = '0;
    endcase
  end

  // Request latch in IDLE and read-data capture at the edge closing ACCESS.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tgt_q <= T_NONE;
      idx_q <= '0;
      we_q  <= 1'b0;
      wd_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (state_q == IDLE && PrReq) begin
        tgt_q <= decode_target(PrAddr[29:4], DEV0_BASE[31:6],
                               DEV1_BASE[31:6], IRQ_BASE[31:6]);
        idx_q <= PrAddr[3:0];
        we_q  <= PrWE;
        wd_q  <= PrWD;
      end
      if (state_q == ACCESS) rd_q <= rd_mux;
    end
  end

  // Internal register writes land on the same edge as a device write would.
  assign irq_wr      = (state_q == ACCESS) && (tgt_q == T_IRQ) && we_q;
  assign irq_clr     = (irq_wr && idx_q == REG_PEND) ? wd_q[IRQ_W-1:0] : '0;
  assign irq_mask_we = irq_wr && (idx_q == REG_MASK);

  irq_pend u_irq_pend (
    .CLK     (CLK),
    .RST     (RST),
    .irq_in  ({DEV_IRQ1, DEV_IRQ0}),
    .clr     (irq_clr),
    .mask_we (irq_mask_we),
    .mask_wd (wd_q[IRQ_W-1:0]),
    .pend    (irq_pend_v),
    .mask    (irq_mask_v),
    .hwint   (HWInt)
  );

endmodule
